// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: NUM_CH channels, each pulsing at an average
// rate of clk*num/den, gated until the PLL is locked and a settle time has elapsed.
module clk_en_gen #(
  parameter int NUM_CH    = 4,
  parameter int ACC_W     = 16,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked_in,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*ACC_W-1:0] num,
  input  logic [NUM_CH*ACC_W-1:0] den,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       ce,
  output logic                    ready
);

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             step_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_in) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        // Lock loss wins over the settle counter reaching its end.
        if (!locked_in) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_in) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign ready = (state == RUN);

  // Accumulators only advance in RUN with lock held and no resync this cycle;
  // every other case forces acc and ce to zero.
  assign step_en = (state == RUN) && locked_in && !resync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W-1:0] n, d;
    logic [ACC_W:0]   s, diff;
    logic             ce_q, ce_nxt;

    assign n    = num[i*ACC_W +: ACC_W];
    assign d    = den[i*ACC_W +: ACC_W];
    assign s    = {1'b0, acc} + {1'b0, n};
    assign diff = s - {1'b0, d};

    always_comb begin
      acc_nxt = '0;
      ce_nxt  = 1'b0;
      if (d == '0 || !ch_en[i]) begin
        acc_nxt = '0;
        ce_nxt  = 1'b0;
      end else if (n >= d) begin
        acc_nxt = '0;
        ce_nxt  = 1'b1;
      end else if (s >= {1'b0, d}) begin
        ce_nxt  = 1'b1;
        // A remainder still >= den only happens after den shrank mid-run.
        acc_nxt = (diff >= {1'b0, d}) ? '0 : diff[ACC_W-1:0];
      end else begin
        acc_nxt = s[ACC_W-1:0];
        ce_nxt  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || !step_en) begin
        acc  <= '0;
        ce_q <= 1'b0;
      end else begin
        acc  <= acc_nxt;
        ce_q <= ce_nxt;
      end
    end

    assign ce[i] = ce_q;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock/settle timing, pulse rates, gating,
// resync phase alignment, den decrease, lock loss and mid-run reset.
module tb_clk_en_gen;

  localparam int NUM_CH    = 4;
  localparam int ACC_W     = 16;
  localparam int LOCK_WAIT = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    locked_in;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*ACC_W-1:0] num;
  logic [NUM_CH*ACC_W-1:0] den;
  logic                    resync;
  logic [NUM_CH-1:0]       ce;
  logic                    ready;

  int total = 0;
  int bad   = 0;

  clk_en_gen #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked_in(locked_in),
    .ch_en    (ch_en),
    .num      (num),
    .den      (den),
    .resync   (resync),
    .ce       (ce),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // Driver tasks: all inputs change 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int n, input int d);
    num[i*ACC_W +: ACC_W] = ACC_W'(n);
    den[i*ACC_W +: ACC_W] = ACC_W'(d);
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    tick();
    resync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_in = 1'b0; ch_en = '0; num = '0; den = '0; resync = 1'b0;
    repeat (3) tick();
    total++;
    if (ready !== 1'b0 || ce !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b ce=%b expected ready=0 ce=0000", ready, ce);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (ready !== 1'b0 || ce !== 4'b0000) begin
        bad++;
        $display("FAIL unlocked_idle: got ready=%b ce=%b expected ready=0 ce=0000", ready, ce);
      end
    end
  endtask

  task automatic test_lock_wait();
    set_ch(0, 1, 2);
    set_ch(1, 1, 4);
    set_ch(2, 5, 5);
    set_ch(3, 3, 0);
    ch_en = 4'hF;
    locked_in = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      total++;
      if (ready !== (n == 17) || ce !== 4'b0000) begin
        bad++;
        $display("FAIL lock_wait[%0d]: got ready=%b ce=%b expected ready=%b ce=0000",
                 n, ready, ce, (n == 17));
      end
    end
  endtask

  task automatic test_ratio();
    int   c0 = 0, c1 = 0, c2 = 0, c3 = 0;
    logic prev0 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (k == 0) begin
        total++;
        if (ce !== 4'b0100) begin
          bad++;
          $display("FAIL run_cycle2_ce: got %b expected 0100", ce);
        end
      end else begin
        total++;
        if (ce[0] === prev0) begin
          bad++;
          $display("FAIL ce0_alternate[%0d]: got %b expected %b", k, ce[0], ~prev0);
        end
      end
      prev0 = ce[0];
      c0 += int'(ce[0]); c1 += int'(ce[1]); c2 += int'(ce[2]); c3 += int'(ce[3]);
    end
    total++;
    if (c0 != 500 || c1 != 250 || c2 != 1000 || c3 != 0) begin
      bad++;
      $display("FAIL ratio_counts: got %0d/%0d/%0d/%0d expected 500/250/1000/0", c0, c1, c2, c3);
    end
  endtask

  task automatic test_gating();
    int cnt3 = 0;
    set_ch(3, 1, 2);
    ch_en = 4'b0111;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (ce[3] !== 1'b0) begin
        bad++;
        $display("FAIL ch_en_gate[%0d]: got ce3=%b expected 0", k, ce[3]);
      end
    end
    ch_en = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt3 += int'(ce[3]);
    end
    total++;
    if (cnt3 != 10) begin
      bad++;
      $display("FAIL ch3_enabled_rate: got %0d expected 10", cnt3);
    end
  endtask

  task automatic test_window_7_24();
    logic h[120];
    int   sum;
    set_ch(0, 7, 24);
    pulse_resync();
    total++;
    if (ce !== 4'b0000) begin
      bad++;
      $display("FAIL resync_clears_ce: got %b expected 0000", ce);
    end
    tick();
    for (int k = 0; k < 120; k++) begin
      tick();
      h[k] = ce[0];
    end
    for (int w = 0; w <= 96; w++) begin
      sum = 0;
      for (int j = 0; j < 24; j++) sum += int'(h[w + j]);
      total++;
      if (sum != 7) begin
        bad++;
        $display("FAIL window_7_24[%0d]: got %0d pulses expected 7", w, sum);
      end
    end
    for (int k = 1; k < 120; k++) begin
      total++;
      if (h[k] && h[k-1]) begin
        bad++;
        $display("FAIL adjacent_7_24[%0d]: got 11 expected no adjacent pulses", k);
      end
    end
  endtask

  task automatic test_resync();
    logic [9:0] pat;
    logic       e;
    pat = 10'b1001001000;
    set_ch(0, 3, 10);
    repeat (5) tick();
    set_ch(1, 3, 10);
    repeat (3) tick();
    pulse_resync();
    for (int k = 1; k <= 40; k++) begin
      tick();
      e = pat[(k - 1) % 10];
      total++;
      if (ce[0] !== e || ce[1] !== e) begin
        bad++;
        $display("FAIL resync_align[%0d]: got ce0=%b ce1=%b expected %b", k, ce[0], ce[1], e);
      end
    end
  endtask

  task automatic test_den_decrease();
    logic [14:0] exp_seq;
    exp_seq = 15'b111011110100000;
    set_ch(0, 4, 24);
    pulse_resync();
    for (int k = 1; k <= 15; k++) begin
      if (k == 6) set_ch(0, 4, 5);
      tick();
      total++;
      if (ce[0] !== exp_seq[k-1]) begin
        bad++;
        $display("FAIL den_decrease[%0d]: got %b expected %b", k, ce[0], exp_seq[k-1]);
      end
    end
  endtask

  task automatic test_lock_loss();
    locked_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (ready !== 1'b0 || ce !== 4'b0000) begin
        bad++;
        $display("FAIL lock_loss[%0d]: got ready=%b ce=%b expected ready=0 ce=0000", k, ready, ce);
      end
    end
    locked_in = 1'b1;
    repeat (8) tick();
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      total++;
      if (ready !== (n == 17) || ce !== 4'b0000) begin
        bad++;
        $display("FAIL relock_wait[%0d]: got ready=%b ce=%b expected ready=%b ce=0000",
                 n, ready, ce, (n == 17));
      end
    end
  endtask

  task automatic test_rst_mid_run();
    tick();
    total++;
    if (ce[2] !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_ce2: got %b expected 1", ce[2]);
    end
    rst = 1'b1;
    tick();
    total++;
    if (ready !== 1'b0 || ce !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_run: got ready=%b ce=%b expected ready=0 ce=0000", ready, ce);
    end
    rst = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      total++;
      if (ready !== (n == 17)) begin
        bad++;
        $display("FAIL post_rst_wait[%0d]: got ready=%b expected %b", n, ready, (n == 17));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_wait();
    test_ratio();
    test_gating();
    test_window_7_24();
    test_resync();
    test_den_decrease();
    test_lock_loss();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
